// File: rtl/sevseg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sevseg_pkg;

  // All segments dark (segments are active-low, order gfedcba).
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Hex glyphs, active-low gfedcba.
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  // Load handshake state: SCAN accepts a word, PENDING waits for the frame boundary.
  typedef enum logic [0:0] {
    SCAN    = 1'b0,
    PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/hex_to_seg.sv
// Nibble to active-low gfedcba seven-segment decoder.
// Latency: purely combinational.
// Backpressure: none; output follows input every cycle.
module hex_to_seg
  import sevseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Full 16-entry lookup; every nibble value has its own glyph.
  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed N-digit common-anode hex display driver; optional leading-zero blanking via SEVSEG_LZB_EN.
// Latency: seg/an registered one cycle after digit_idx; a loaded word is shown from the frame after the next frame boundary.
// Backpressure: load_ready drops after a word is accepted and returns the cycle after the frame-boundary commit.
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_COUNT  = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CNT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        prescaler;
  logic [IDX_W-1:0]        digit_idx;
  logic                    tick;
  logic                    frame_end;
  logic                    fire;
  state_e                  state_q;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [4*NUM_DIGITS-1:0] disp_q;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_seg;
  logic                    dark;

  assign tick      = (prescaler == CNT_LAST);
  assign frame_end = tick && (digit_idx == IDX_LAST);

  // Refresh prescaler: each digit stays lit for DIV_COUNT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Digit scan index advances on every prescaler wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx <= '0;
    end else if (tick) begin
      if (digit_idx == IDX_LAST) begin
        digit_idx <= '0;
      end else begin
        digit_idx <= digit_idx + 1'b1;
      end
    end
  end

  assign load_ready = (state_q == SCAN);
  assign fire       = load_valid && load_ready;

  // Load FSM: capture into shadow, commit only at a frame boundary seen while
  // PENDING, so a word accepted on a frame_end waits for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SCAN;
      shadow_q <= '0;
      disp_q   <= '0;
    end else if (state_q == SCAN) begin
      if (fire) begin
        shadow_q <= load_data;
        state_q  <= PENDING;
      end
    end else if (frame_end) begin
      disp_q  <= shadow_q;
      state_q <= SCAN;
    end
  end

  assign cur_nib = disp_q[{digit_idx, 2'b00} +: 4];

  hex_to_seg u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

`ifdef SEVSEG_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_mask;

  // Leading-zero mask from the committed word: a digit goes dark when it and
  // every digit above it are zero; digit 0 always stays visible.
  always_comb begin
    logic zero_run;
    lzb_mask = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (disp_q[4*i +: 4] == 4'h0);
      lzb_mask[i] = zero_run;
    end
  end

  assign dark = blank_mask[digit_idx] | lzb_mask[digit_idx];
`else
  assign dark = blank_mask[digit_idx];
`endif

  // Registered pin drivers: one anode low, segments decoded or forced dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else begin
      seg <= dark ? SEG_OFF : dec_seg;
      an  <= ~(NUM_DIGITS'(1) << digit_idx);
    end
  end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed self-checking bench for sevseg_scan_driver (NUM_DIGITS=4, DIV_COUNT=4).
// Expected glyphs are hand-written literals; timing is tracked by counting clock edges since reset release.
// Define SEVSEG_LZB_EN on both RTL and bench to exercise leading-zero blanking.
module tb_sevseg_scan_driver;

  localparam int ND = 4;
  localparam int DC = 4;

  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_1   = 7'b1111001;
  localparam logic [6:0] S_2   = 7'b0100100;
  localparam logic [6:0] S_3   = 7'b0110000;
  localparam logic [6:0] S_4   = 7'b0011001;
  localparam logic [6:0] S_5   = 7'b0010010;
  localparam logic [6:0] S_6   = 7'b0000010;
  localparam logic [6:0] S_7   = 7'b1111000;
  localparam logic [6:0] S_8   = 7'b0000000;
  localparam logic [6:0] S_9   = 7'b0010000;
  localparam logic [6:0] S_A   = 7'b0001000;
  localparam logic [6:0] S_B   = 7'b0000011;
  localparam logic [6:0] S_C   = 7'b1000110;
  localparam logic [6:0] S_OFF = 7'b1111111;
`ifdef SEVSEG_LZB_EN
  localparam logic [6:0] S_LZ  = S_OFF;
`else
  localparam logic [6:0] S_LZ  = S_0;
`endif

  logic            clk;
  logic            rst_n;
  logic            load_valid;
  logic            load_ready;
  logic [4*ND-1:0] load_data;
  logic [ND-1:0]   blank_mask;
  logic [6:0]      seg;
  logic [ND-1:0]   an;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt;
  logic [3:0] an_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  sevseg_scan_driver #(
    .NUM_DIGITS (ND),
    .DIV_COUNT  (DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_mask (blank_mask),
    .seg        (seg),
    .an         (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to the falling edge that follows rising edge number e.
  task automatic at_edge(input int e);
    int guard;
    guard = 0;
    @(negedge clk);
    while (edge_cnt < e && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    blank_mask = '0;
    #12;
    // 1. Reset values and scan sequence
    check_val("rst_seg", 32'(seg), 32'(S_OFF));
    check_val("rst_an", 32'(an), 32'hF);
    check_val("rst_rdy", 32'(load_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      at_edge(e);
      check_val($sformatf("scan_an_e%0d", e), 32'(an), 32'(an_exp[((e - 1) / 4) % 4]));
      check_val($sformatf("scan_seg_e%0d", e), 32'(seg),
                32'((((e - 1) / 4) % 4 == 0) ? S_0 : S_LZ));
    end

    // 2. Load 0x1234 during SCAN
    load_valid = 1'b1;
    load_data  = 16'h1234;
    at_edge(21);
    check_val("t2_rdy_lo", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    load_data  = 16'hDEAD;
    at_edge(31);
    check_val("t2_rdy_hold", 32'(load_ready), 32'd0);
    at_edge(32);
    check_val("t2_rdy_back", 32'(load_ready), 32'd1);
    check_val("t2_old_d3", 32'(seg), 32'(S_LZ));
    at_edge(33);
    check_val("t2_d0_an", 32'(an), 32'hE);
    check_val("t2_d0", 32'(seg), 32'(S_4));
    at_edge(37);
    check_val("t2_d1", 32'(seg), 32'(S_3));
    at_edge(41);
    check_val("t2_d2", 32'(seg), 32'(S_2));
    at_edge(45);
    check_val("t2_d3_an", 32'(an), 32'h7);
    check_val("t2_d3", 32'(seg), 32'(S_1));

    // 3. Second word offered while PENDING is held off
    at_edge(50);
    load_valid = 1'b1;
    load_data  = 16'h5678;
    at_edge(51);
    check_val("t3_rdy_lo", 32'(load_ready), 32'd0);
    load_data  = 16'h9ABC;
    at_edge(63);
    check_val("t3_rdy_hold", 32'(load_ready), 32'd0);
    at_edge(64);
    check_val("t3_rdy_back", 32'(load_ready), 32'd1);
    at_edge(65);
    check_val("t3_rdy_retake", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    check_val("t3_w1_d0", 32'(seg), 32'(S_8));
    at_edge(69);
    check_val("t3_w1_d1", 32'(seg), 32'(S_7));
    at_edge(73);
    check_val("t3_w1_d2", 32'(seg), 32'(S_6));
    at_edge(77);
    check_val("t3_w1_d3", 32'(seg), 32'(S_5));
    at_edge(80);
    check_val("t3_rdy_end", 32'(load_ready), 32'd1);
    at_edge(81);
    check_val("t3_w2_d0", 32'(seg), 32'(S_C));
    at_edge(85);
    check_val("t3_w2_d1", 32'(seg), 32'(S_B));
    at_edge(89);
    check_val("t3_w2_d2", 32'(seg), 32'(S_A));
    at_edge(93);
    check_val("t3_w2_d3", 32'(seg), 32'(S_9));

    // 4. Load accepted on the frame_end cycle waits a full frame
    at_edge(95);
    load_valid = 1'b1;
    load_data  = 16'h8888;
    at_edge(96);
    check_val("t4_rdy_lo", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    at_edge(97);
    check_val("t4_old_d0", 32'(seg), 32'(S_C));
    at_edge(101);
    check_val("t4_old_d1", 32'(seg), 32'(S_B));
    at_edge(109);
    check_val("t4_old_d3", 32'(seg), 32'(S_9));
    at_edge(111);
    check_val("t4_rdy_hold", 32'(load_ready), 32'd0);
    at_edge(112);
    check_val("t4_rdy_back", 32'(load_ready), 32'd1);
    at_edge(113);
    check_val("t4_new_an", 32'(an), 32'hE);
    check_val("t4_new_d0", 32'(seg), 32'(S_8));

    // 5. Live blank mask, then reset mid-frame with a pending word
    at_edge(116);
    blank_mask = 4'b0101;
    at_edge(117);
    check_val("t5_d1", 32'(seg), 32'(S_8));
    at_edge(121);
    check_val("t5_d2_an", 32'(an), 32'hB);
    check_val("t5_d2", 32'(seg), 32'(S_OFF));
    at_edge(125);
    check_val("t5_d3", 32'(seg), 32'(S_8));
    at_edge(129);
    check_val("t5_d0", 32'(seg), 32'(S_OFF));
    load_valid = 1'b1;
    load_data  = 16'h1111;
    at_edge(130);
    load_valid = 1'b0;
    at_edge(131);
    check_val("t5_pend_rdy", 32'(load_ready), 32'd0);
    at_edge(132);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_seg", 32'(seg), 32'(S_OFF));
    check_val("t5_rst_an", 32'(an), 32'hF);
    check_val("t5_rst_rdy", 32'(load_ready), 32'd1);
    blank_mask = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 6. Zero word after reset and 0x0040 (leading zeros blanked when enabled)
    at_edge(1);
    check_val("t6_z_d0_an", 32'(an), 32'hE);
    check_val("t6_z_d0", 32'(seg), 32'(S_0));
    at_edge(5);
    check_val("t6_z_d1", 32'(seg), 32'(S_LZ));
    at_edge(13);
    check_val("t6_z_d3", 32'(seg), 32'(S_LZ));
    at_edge(17);
    check_val("t6_discard_d0", 32'(seg), 32'(S_0));
    check_val("t6_discard_rdy", 32'(load_ready), 32'd1);
    at_edge(20);
    load_valid = 1'b1;
    load_data  = 16'h0040;
    at_edge(21);
    load_valid = 1'b0;
    at_edge(33);
    check_val("t6_40_d0", 32'(seg), 32'(S_0));
    at_edge(37);
    check_val("t6_40_d1", 32'(seg), 32'(S_4));
    at_edge(41);
    check_val("t6_40_d2", 32'(seg), 32'(S_LZ));
    at_edge(45);
    check_val("t6_40_d3", 32'(seg), 32'(S_LZ));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
- Accepts a packed hex word through a valid/ready handshake and holds it in a shadow register.
- Commits the word atomically at a scan-frame boundary, then scans one digit at a time with a programmable refresh prescaler.
- Sits between the datapath and the board display pins; it generalises the single-digit hex decoder to N digits with refresh, blanking and handshake.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- DIV_COUNT, 100000, clk cycles each digit is lit; legal minimum 1.
- CNT_W, $clog2(DIV_COUNT) (min 1), prescaler width; localparam, not overridable.
- IDX_W, $clog2(NUM_DIGITS) (min 1), digit index width; localparam.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  new display word offered.
- load_ready  output  1  block can accept a word.
- load_data  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant (rightmost).
- blank_mask  input  NUM_DIGITS  bit i=1 forces digit i dark; sampled live, not latched.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- an  output  NUM_DIGITS  digit enables, active-low, one-hot-cold.

Behaviour:
- Reset (asynchronous, active-low; release treated as synchronous): all internal state is cleared to these values.
  - seg = 7'b1111111, an = all ones.
  - prescaler = 0, digit_idx = 0.
  - display register = 0, shadow register = 0.
  - state = SCAN, load_ready = 1.
  - Reset mid-operation discards any pending word.
- Prescaler: counts 0..DIV_COUNT-1 and wraps.
  - tick = (prescaler == DIV_COUNT-1).
  - With DIV_COUNT=1, tick is high every cycle.
- Digit index: on tick, digit_idx increments; from NUM_DIGITS-1 it wraps to 0.
  - frame_end = tick && (digit_idx == NUM_DIGITS-1).
- State machine (2 states):
  - SCAN: load_ready = 1. Handshake fires when load_valid && load_ready. On a fire, load_data is captured into the shadow register and the state goes to PENDING.
  - PENDING: load_ready = 0. On frame_end, shadow is copied to the display register and the state returns to SCAN, so load_ready = 1 the next cycle.
  - A fire on the same cycle as frame_end does NOT commit on that frame_end; it waits for the following one. This guarantees every frame shows one coherent word.
- Outputs are registered with 1-cycle latency from digit_idx.
  - an = ~(1 << digit_idx).
  - seg = decode(display nibble[digit_idx]), or 7'b1111111 if blank_mask[digit_idx] is set.
- Decode table (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - All 16 codes are mapped, with no duplicates and no default hole.
- Exactly one an bit is low at any time after the first post-reset cycle; there is no all-on state.

Optional Feature:
- Macro: SEVSEG_LZB_EN (leading-zero blanking).
- Defined: digit i is additionally blanked when its display nibble and all display nibbles above it are 0. Digit 0 is never blanked by this rule. Example: 0x0040 shows "  40"; 0x0000 shows "   0".
- Undefined: only blank_mask blanks digits; zeros are shown.
- Blanking is evaluated on the committed display register, never on the shadow register.

Decomposition:
- Package sevseg_pkg holds:
  - SEG_OFF = 7'b1111111.
  - The 16-entry decode constants.
  - The state enum {SCAN, PENDING}.
- Sub-module hex_to_seg: purely combinational nibble-to-segment decoder. Instantiate it once on the muxed nibble.

Test Plan (NUM_DIGITS=4, DIV_COUNT=4):
1. Reset → seg=7F, an=F, load_ready=1; after release, an steps E,D,B,7, each held 4 cycles, then wraps to E.
2. Load 0x1234 during SCAN → load_ready=0 until frame_end; next frame shows digit0 seg=0011001 (4), d1 0110000, d2 0100100, d3 1111001.
3. Second load_valid held while PENDING → not accepted; the shadow word is unchanged and the new word is taken only once load_ready=1.
4. Load asserted exactly on frame_end cycle → commit deferred one full frame (16 cycles); the old word is shown for the intervening frame.
5. blank_mask=4'b0101 with display 0x8888 → digits 0 and 2 give seg=7F, digits 1 and 3 give 0000000; reset asserted mid-frame → outputs return to 7F/F immediately.
6. With SEVSEG_LZB_EN, display 0x0040 → d3 and d2 give 7F, d1 0011001, d0 1000000; display 0x0000 → only d0 lit with 1000000.
